// File: rtl/mem_responder.sv
// Wait-stated synchronous word RAM answering the datapath's Read/Write strobes
// with a four-phase Done handshake; read data is presented toward Mdatain.
module mem_responder #(
   parameter int DEPTH       = 512,
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        Read,
   input  logic        Write,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        Done,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t              state;
   logic [3:0]          cnt;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         data_q;
   logic [31:0]         mem [DEPTH];

   logic                acc_fire;
   logic                acc_wr;
   logic [ADDR_W-1:0]   acc_addr;
   logic [31:0]         acc_data;

   logic                unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_W];

   // With zero wait states the access uses the live inputs on the capture edge.
   always_comb begin
      acc_fire = 1'b0;
      acc_wr   = wr_q;
      acc_addr = addr_q;
      acc_data = data_q;
      case (state)
         S_IDLE: begin
            if (WAIT_CYCLES == 0 && (Read ^ Write)) begin
               acc_fire = 1'b1;
               acc_wr   = Write;
               acc_addr = addr[ADDR_W-1:0];
               acc_data = data_in;
            end
         end
         S_WAIT: begin
            if ((Read || Write) && cnt == LAST)
               acc_fire = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr && acc_fire && acc_wr)
         mem[acc_addr] <= acc_data;
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && (Read || Write)) begin
         addr_q <= addr[ADDR_W-1:0];
         data_q <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         wr_q     <= 1'b0;
         data_out <= 32'd0;
         Done     <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Read || Write) begin
                  wr_q <= Write;
                  cnt  <= 4'd0;
                  busy <= 1'b1;
                  if (Read && Write) begin
                     state <= S_RESP;
                     Done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (WAIT_CYCLES == 0) begin
                     state <= S_RESP;
                     Done  <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // A dropped request wins even on the edge that would complete it.
               if (!Read && !Write) begin
                  state <= S_IDLE;
                  cnt   <= 4'd0;
                  busy  <= 1'b0;
               end else if (cnt == LAST) begin
                  state <= S_RESP;
                  Done  <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_RESP: begin
               if (!Read && !Write) begin
                  state <= S_IDLE;
                  Done  <= 1'b0;
                  err   <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               Done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
         if (acc_fire && !acc_wr)
            data_out <= mem[acc_addr];
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed handshake scenarios plus randomized traffic
// scored against an array model of the RAM and a fixed-latency handshake model.
module tb_mem_responder;

   localparam int WC = 2;

   logic        clk;
   logic        clr;
   logic        Read, Write;
   logic [31:0] addr, data_in, data_out;
   logic        Done, busy, err;

   logic        r0, w0;
   logic [31:0] a0, d0, dout0;
   logic        done0, busy0, err0;

   int          n_cmp;
   int          n_err;
   logic [31:0] ref_mem [512];
   logic [31:0] ref_dout;

   mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .clr(clr), .Read(Read), .Write(Write), .addr(addr),
      .data_in(data_in), .data_out(data_out), .Done(Done), .busy(busy), .err(err)
   );

   mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .clr(clr), .Read(r0), .Write(w0), .addr(a0),
      .data_in(d0), .data_out(dout0), .Done(done0), .busy(busy0), .err(err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transfer on the WC-wait-state instance, with strobes held `hold` extra cycles.
   task automatic xfer(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
      int lat;
      lat = (rd && wr) ? 0 : WC;
      Read = rd; Write = wr; addr = a; data_in = d;
      tick;
      addr = $urandom; data_in = $urandom;
      check("busy_after_capture", {31'd0, busy}, 32'd1);
      for (int i = 1; i <= lat; i++) begin
         check("done_early", {31'd0, Done}, 32'd0);
         check("busy_wait", {31'd0, busy}, 32'd1);
         tick;
      end
      if (!(rd && wr)) begin
         if (wr) ref_mem[a[8:0]] = d;
         else    ref_dout = ref_mem[a[8:0]];
      end
      check("done_rise", {31'd0, Done}, 32'd1);
      check("err_resp", {31'd0, err}, {31'd0, rd && wr});
      check("data_out_resp", data_out, ref_dout);
      for (int i = 0; i < hold; i++) begin
         data_in = $urandom;
         tick;
         check("done_held", {31'd0, Done}, 32'd1);
         check("data_out_held", data_out, ref_dout);
      end
      Read = 1'b0; Write = 1'b0;
      tick;
      check("done_fall", {31'd0, Done}, 32'd0);
      check("busy_fall", {31'd0, busy}, 32'd0);
      check("err_fall", {31'd0, err}, 32'd0);
   endtask

   // Write dropped after k edges following capture (1..WC); never completes.
   task automatic abort_wr(input logic [31:0] a, input logic [31:0] d, input int k);
      Read = 1'b0; Write = 1'b1; addr = a; data_in = d;
      tick;
      for (int i = 1; i < k; i++) begin
         check("abort_done_wait", {31'd0, Done}, 32'd0);
         tick;
      end
      Write = 1'b0;
      tick;
      check("abort_done", {31'd0, Done}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, d;
      int kind;
      n_cmp = 0; n_err = 0; ref_dout = 32'd0;
      clr = 1'b1; Read = 1'b0; Write = 1'b0; addr = '0; data_in = '0;
      r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
      tick; tick;
      clr = 1'b0;
      check("rst_data_out", data_out, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);

      // Fill every word through the bus, using aliased addresses.
      for (int i = 0; i < 512; i++) begin
         a = $urandom;
         a[8:0] = i[8:0];
         xfer(1'b0, 1'b1, a, $urandom, 0);
      end

      xfer(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0001, 0);
      xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
      check("rd_after_wr", data_out, 32'h0000_0001);

      xfer(1'b0, 1'b1, 32'h0000_0205, 32'hFFFF_FFFF, 0);
      xfer(1'b1, 1'b0, 32'h0000_0005, 32'h0, 0);
      check("alias_read", data_out, 32'hFFFF_FFFF);

      xfer(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1);
      xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
      check("err_no_access", data_out, 32'h0000_0001);

      xfer(1'b0, 1'b1, 32'h0000_0020, 32'h0, 0);
      abort_wr(32'h0000_0020, 32'hDEAD_BEEF, 1);
      abort_wr(32'h0000_0020, 32'hDEAD_BEEF, WC);
      xfer(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0);
      check("abort_no_write", data_out, 32'h0);

      xfer(1'b1, 1'b0, 32'h0000_0205, 32'h0, 5);
      xfer(1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4);
      xfer(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0);
      check("held_write_once", data_out, 32'h0BAD_F00D);

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         a = $urandom;
         if (kind == 0)      xfer(1'b1, 1'b1, a, $urandom, $urandom_range(0, 3));
         else if (kind == 1) abort_wr(a, $urandom, $urandom_range(1, WC));
         else if (kind < 6)  xfer(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3));
         else                xfer(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3));
      end

      // Reset mid-WAIT of a read, then of a write that must be dropped.
      xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
      Read = 1'b1; addr = 32'h0000_0010;
      tick; tick;
      clr = 1'b1; Read = 1'b0;
      tick;
      clr = 1'b0;
      ref_dout = 32'd0;
      check("clr_data_out", data_out, 32'd0);
      check("clr_done", {31'd0, Done}, 32'd0);
      check("clr_busy", {31'd0, busy}, 32'd0);
      check("clr_err", {31'd0, err}, 32'd0);
      tick;
      check("clr_idle", {31'd0, busy}, 32'd0);
      Write = 1'b1; addr = 32'h0000_0010; data_in = 32'hCAFE_0000;
      tick; tick;
      clr = 1'b1; Write = 1'b0;
      tick;
      clr = 1'b0;
      xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
      check("clr_drops_write", data_out, 32'h0000_0001);

      // Zero wait states: Done in the cycle after capture.
      d = $urandom;
      w0 = 1'b1; a0 = 32'h0000_0077; d0 = d;
      tick;
      check("w0_done", {31'd0, done0}, 32'd1);
      w0 = 1'b0;
      tick;
      check("w0_done_fall", {31'd0, done0}, 32'd0);
      r0 = 1'b1; a0 = 32'h0000_0677;
      tick;
      check("r0_done", {31'd0, done0}, 32'd1);
      check("r0_data", dout0, d);
      for (int i = 0; i < 5; i++) begin
         tick;
         check("r0_done_held", {31'd0, done0}, 32'd1);
         check("r0_data_held", dout0, d);
      end
      r0 = 1'b0;
      tick;
      check("r0_done_fall", {31'd0, done0}, 32'd0);
      check("r0_busy_fall", {31'd0, busy0}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
